// File: rtl/conversor_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   - state_e      : converter FSM states
//   - SEG_*        : active-low {g,f,e,d,c,b,a} seven-segment patterns
//   - seg_of_digit : BCD digit to segment pattern, blank for codes 10-15
//   - pow10        : elaboration-time power of ten for the range check
package conversor_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    function automatic logic [6:0] seg_of_digit(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/deco_7seg.sv
// Combinational BCD digit to seven-segment decoder.
//   bcd_i   : BCD digit (codes 10-15 display blank)
//   blank_i : force the digit dark
//   seg_o   : active-low {g,f,e,d,c,b,a}
module deco_7seg
    import conversor_bcd_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            seg_o = seg_of_digit(bcd_i);
        end
    end

endmodule

// File: rtl/conversor_bcd_secuencial.sv
// Sequential signed binary to BCD converter with seven-segment outputs.
// A captured two's-complement product is converted to sign + magnitude and
// the magnitude is turned into BCD by double-dabble, one bit per clock.
//   Clk_Input              : clock, rising edge
//   Reset_Input            : asynchronous active-low reset
//   Valid_Input            : start request (ignored while busy)
//   Product_Input          : signed product, 2*Word_Length bits
//   Busy_Output            : high whenever not idle
//   Done_Output            : one-cycle pulse when a new result is registered
//   Sign_Output            : result negative
//   BCD_Output             : magnitude in BCD, units in [3:0]
//   Segmentos_output       : per-digit active-low segments, units in [6:0]
//   Signo_Segmentos_output : minus sign display, active-low
module conversor_bcd_secuencial
    import conversor_bcd_pkg::*;
#(
    parameter int Word_Length = 6,
    parameter int Digit_Count = 4
) (
    input  logic                     Clk_Input,
    input  logic                     Reset_Input,
    input  logic                     Valid_Input,
    input  logic [2*Word_Length-1:0] Product_Input,
    output logic                     Busy_Output,
    output logic                     Done_Output,
    output logic                     Sign_Output,
    output logic [4*Digit_Count-1:0] BCD_Output,
    output logic [7*Digit_Count-1:0] Segmentos_output,
    output logic [6:0]               Signo_Segmentos_output
);

    localparam int PW = 2 * Word_Length;
    localparam int BW = 4 * Digit_Count;
    localparam int CW = $clog2(PW) + 1;

    localparam longint unsigned MAX_MAG = 64'd1 << (PW - 1);

    // The most negative product must fit in the available digits.
    if (MAX_MAG > pow10(Digit_Count) - 64'd1) begin : g_range_check
        $error("conversor_bcd_secuencial: Digit_Count too small for Word_Length");
    end

    state_e          state_q, state_d;
    logic [PW-1:0]   product_q, product_d;
    logic [PW-1:0]   mag_q, mag_d;
    logic            sign_q, sign_d;
    logic [BW-1:0]   scratch_q, scratch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            sign_out_q, sign_out_d;
    logic            done_q, done_d;

    logic [BW-1:0]   scratch_adj;
    logic [Digit_Count-1:0] blank;

    // Double-dabble correction: any digit >= 5 gets +3 before the shift.
    for (genvar gi = 0; gi < Digit_Count; gi++) begin : g_adjust
        assign scratch_adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                                        scratch_q[4*gi +: 4] + 4'd3 :
                                        scratch_q[4*gi +: 4];
    end

    always_comb begin
        state_d    = state_q;
        product_d  = product_q;
        mag_d      = mag_q;
        sign_d     = sign_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        sign_out_d = sign_out_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Valid_Input) begin
                    product_d = Product_Input;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sign_d    = product_q[PW-1];
                // Negation in PW bits maps the most-negative value onto its
                // exact unsigned magnitude.
                mag_d     = product_q[PW-1] ? (~product_q + 1'b1) : product_q;
                scratch_d = '0;
                cnt_d     = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                scratch_d = {scratch_adj[BW-2:0], mag_q[PW-1]};
                mag_d     = {mag_q[PW-2:0], 1'b0};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CW'(PW - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d      = scratch_q;
                sign_out_d = sign_q && (scratch_q != '0);
                done_d     = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_Input or negedge Reset_Input) begin
        if (!Reset_Input) begin
            state_q    <= ST_IDLE;
            product_q  <= '0;
            mag_q      <= '0;
            sign_q     <= 1'b0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            sign_out_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            product_q  <= product_d;
            mag_q      <= mag_d;
            sign_q     <= sign_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            sign_out_q <= sign_out_d;
            done_q     <= done_d;
        end
    end

    assign Busy_Output = (state_q != ST_IDLE);
    assign Done_Output = done_q;
    assign Sign_Output = sign_out_q;
    assign BCD_Output  = bcd_q;

    // A digit is blanked when it and every more significant digit are zero;
    // the units digit is always shown.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank    = '0;
        for (int i = Digit_Count - 1; i >= 1; i--) begin
            zero_run = zero_run && (bcd_q[4*i +: 4] == 4'd0);
            blank[i] = zero_run;
        end
    end

    for (genvar gi = 0; gi < Digit_Count; gi++) begin : g_deco
        deco_7seg u_deco (
            .bcd_i   (bcd_q[4*gi +: 4]),
            .blank_i (blank[gi]),
            .seg_o   (Segmentos_output[7*gi +: 7])
        );
    end

    assign Signo_Segmentos_output = (sign_out_q && (bcd_q != '0)) ? SEG_MINUS : SEG_BLANK;

endmodule

// File: tb/tb_conversor_bcd_secuencial.sv
module tb_conversor_bcd_secuencial;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [11:0] product;
    logic        busy;
    logic        done;
    logic        sign;
    logic [15:0] bcd;
    logic [27:0] seg;
    logic [6:0]  signo;

    int checks   = 0;
    int failures = 0;

    conversor_bcd_secuencial #(
        .Word_Length (6),
        .Digit_Count (4)
    ) dut (
        .Clk_Input              (clk),
        .Reset_Input            (rst_n),
        .Valid_Input            (valid),
        .Product_Input          (product),
        .Busy_Output            (busy),
        .Done_Output            (done),
        .Sign_Output            (sign),
        .BCD_Output             (bcd),
        .Segmentos_output       (seg),
        .Signo_Segmentos_output (signo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int ref_mag(input logic [11:0] p);
        int v;
        v = $signed(p);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic ref_sign(input logic [11:0] p);
        int v;
        v = $signed(p);
        return v < 0;
    endfunction

    function automatic logic [15:0] ref_bcd(input int mag);
        logic [15:0] r;
        int m;
        m = mag;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] ref_digit_seg(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    function automatic logic [27:0] ref_seg(input int mag);
        int digits [4];
        int m;
        bit leading;
        logic [27:0] r;
        m = mag;
        for (int i = 0; i < 4; i++) begin
            digits[i] = m % 10;
            m = m / 10;
        end
        leading = 1'b1;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (i > 0 && leading && digits[i] == 0) begin
                r[7*i +: 7] = 7'h7F;
            end else begin
                leading = 1'b0;
                r[7*i +: 7] = ref_digit_seg(digits[i]);
            end
        end
        return r;
    endfunction

    // Drive one start request; return the cycle count from capture to Done
    // (-1 if Done never came) and Busy as seen right after the capture edge.
    task automatic do_conv(input logic [11:0] p, output int lat, output logic busy_cap);
        @(negedge clk);
        valid   = 1'b1;
        product = p;
        @(posedge clk);
        #1;
        valid    = 1'b0;
        busy_cap = busy;
        lat      = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        $display("conv product=%h bcd=%h sign=%b latency=%0d", p, bcd, sign, lat);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n   = 1'b0;
        valid   = 1'b0;
        product = '0;
        #12;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++;
        if (sign !== 1'b0) begin failures++; $display("FAIL reset_sign got=%b exp=0", sign); end
        checks++;
        if (bcd !== 16'h0000) begin failures++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
        checks++;
        if (seg !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin
            failures++; $display("FAIL reset_seg got=%h exp=%h", seg, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        end
        checks++;
        if (signo !== 7'h7F) begin failures++; $display("FAIL reset_signo got=%h exp=7f", signo); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [11:0] vec_p   [4] = '{12'h000, 12'hC20, 12'h400, 12'h800};
        logic [15:0] vec_bcd [4] = '{16'h0000, 16'h0992, 16'h1024, 16'h2048};
        logic        vec_s   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [6:0]  vec_sg  [4] = '{7'h7F, 7'h3F, 7'h7F, 7'h3F};
        int lat;
        logic bc;
        for (int i = 0; i < 4; i++) begin
            do_conv(vec_p[i], lat, bc);
            checks++;
            if (bc !== 1'b1) begin failures++; $display("FAIL dir_busy[%0d] got=%b exp=1", i, bc); end
            checks++;
            if (lat != 14) begin failures++; $display("FAIL dir_latency[%0d] got=%0d exp=14", i, lat); end
            checks++;
            if (bcd !== vec_bcd[i]) begin failures++; $display("FAIL dir_bcd[%0d] got=%h exp=%h", i, bcd, vec_bcd[i]); end
            checks++;
            if (sign !== vec_s[i]) begin failures++; $display("FAIL dir_sign[%0d] got=%b exp=%b", i, sign, vec_s[i]); end
            checks++;
            if (signo !== vec_sg[i]) begin failures++; $display("FAIL dir_signo[%0d] got=%h exp=%h", i, signo, vec_sg[i]); end
            checks++;
            if (seg !== ref_seg(ref_mag(vec_p[i]))) begin
                failures++; $display("FAIL dir_seg[%0d] got=%h exp=%h", i, seg, ref_seg(ref_mag(vec_p[i])));
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin failures++; $display("FAIL dir_done_width[%0d] got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_random;
        logic [11:0] p;
        int lat;
        logic bc;
        int m;
        for (int i = 0; i < 20; i++) begin
            p = 12'($urandom_range(0, 4095));
            m = ref_mag(p);
            do_conv(p, lat, bc);
            checks++;
            if (lat != 14) begin failures++; $display("FAIL rnd_latency p=%h got=%0d exp=14", p, lat); end
            checks++;
            if (bcd !== ref_bcd(m)) begin failures++; $display("FAIL rnd_bcd p=%h got=%h exp=%h", p, bcd, ref_bcd(m)); end
            checks++;
            if (sign !== ref_sign(p)) begin failures++; $display("FAIL rnd_sign p=%h got=%b exp=%b", p, sign, ref_sign(p)); end
            checks++;
            if (seg !== ref_seg(m)) begin failures++; $display("FAIL rnd_seg p=%h got=%h exp=%h", p, seg, ref_seg(m)); end
            checks++;
            if (signo !== (ref_sign(p) ? 7'h3F : 7'h7F)) begin
                failures++; $display("FAIL rnd_signo p=%h got=%h exp=%h", p, signo, ref_sign(p) ? 7'h3F : 7'h7F);
            end
            // Results must hold after the Done pulse.
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || bcd !== ref_bcd(m)) begin
                failures++; $display("FAIL rnd_hold p=%h done=%b bcd=%h exp_bcd=%h", p, done, bcd, ref_bcd(m));
            end
        end
    endtask

    task automatic test_ignore_busy;
        int pulses;
        int first_lat;
        @(negedge clk);
        valid   = 1'b1;
        product = 12'h001;
        @(posedge clk);
        #1;
        valid = 1'b0;
        pulses    = 0;
        first_lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 3) begin
                @(negedge clk);
                valid   = 1'b1;
                product = 12'h002;
                @(posedge clk);
                #1;
                valid = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                pulses++;
                if (first_lat < 0) first_lat = k;
            end
        end
        $display("conv product=001 (002 while busy) bcd=%h pulses=%0d latency=%0d", bcd, pulses, first_lat);
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL busy_pulses got=%0d exp=1", pulses); end
        checks++;
        if (first_lat != 14) begin failures++; $display("FAIL busy_latency got=%0d exp=14", first_lat); end
        checks++;
        if (bcd !== 16'h0001) begin failures++; $display("FAIL busy_bcd got=%h exp=0001", bcd); end
    endtask

    task automatic test_back_to_back;
        int lat1;
        int lat2;
        logic [15:0] bcd1;
        @(negedge clk);
        valid   = 1'b1;
        product = 12'h123;
        @(posedge clk);
        #1;
        product = 12'hF9C;  // -100, picked up by the follow-on conversion
        lat1 = -1;
        lat2 = -1;
        bcd1 = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (lat1 < 0) begin
                    lat1 = k;
                    bcd1 = bcd;
                end else if (lat2 < 0) begin
                    lat2 = k;
                end
            end
        end
        valid = 1'b0;
        $display("conv back_to_back first=%h@%0d second=%h@%0d sign=%b", bcd1, lat1, bcd, lat2, sign);
        checks++;
        if (lat1 != 14 || bcd1 !== ref_bcd(12'h123)) begin
            failures++; $display("FAIL b2b_first lat=%0d bcd=%h exp_lat=14 exp_bcd=%h", lat1, bcd1, ref_bcd(12'h123));
        end
        checks++;
        if (lat2 != 29) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=29", lat2); end
        checks++;
        if (bcd !== 16'h0100 || sign !== 1'b1) begin
            failures++; $display("FAIL b2b_second_result bcd=%h sign=%b exp_bcd=0100 exp_sign=1", bcd, sign);
        end
        // Let any conversion started by the trailing valid finish.
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset_mid_shift;
        int lat;
        logic bc;
        @(negedge clk);
        valid   = 1'b1;
        product = 12'h3FF;
        @(posedge clk);
        #1;
        valid = 1'b0;
        // Edge 1 is LOAD; edges 2..6 are SHIFT cycles 1..5.
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0 || sign !== 1'b0 || bcd !== 16'h0000) begin
            failures++; $display("FAIL midrst_outputs done=%b sign=%b bcd=%h exp=0/0/0000", done, sign, bcd);
        end
        checks++;
        if (seg !== {7'h7F, 7'h7F, 7'h7F, 7'h40} || signo !== 7'h7F) begin
            failures++; $display("FAIL midrst_seg seg=%h signo=%h", seg, signo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_conv(12'h005, lat, bc);
        checks++;
        if (lat != 14) begin failures++; $display("FAIL midrst_latency got=%0d exp=14", lat); end
        checks++;
        if (bcd !== 16'h0005 || sign !== 1'b0) begin
            failures++; $display("FAIL midrst_result bcd=%h sign=%b exp=0005/0", bcd, sign);
        end
        checks++;
        if (seg !== ref_seg(5)) begin failures++; $display("FAIL midrst_seg5 got=%h exp=%h", seg, ref_seg(5)); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
